cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Arbitrates the single off-chip memory port between the I-cache and the D-cache miss/write-back engines, which sit under the pipeline core. Each cache presents a line-granular read or write request and holds it until it sees a one-cycle ready pulse. The arbiter grants one requester at a time and drives the shared memory port from registered copies of that request. It returns read data and the ready pulse to the granted cache only.

## Interface
Parameters:
- ADDR_W, 28, line address width (byte address [31:4])
- DATA_W, 128, line width in bits

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_read  in  1  I-cache line read request, level, held until i_ready
- i_write  in  1  I-cache write request; tied 0 in the current core, still supported
- i_addr  in  ADDR_W  I-cache line address
- i_wdata  in  DATA_W  I-cache write data
- i_rdata  out  DATA_W  read data to I-cache, valid while i_ready=1
- i_ready  out  1  one-cycle completion pulse to I-cache
- d_read, d_write, d_addr, d_wdata  in  1/1/ADDR_W/DATA_W  D-cache request, same rules as the I side
- d_rdata  out  DATA_W  read data to D-cache
- d_ready  out  1  completion pulse to D-cache
- mem_read  out  1  memory read strobe, held until mem_ready
- mem_write  out  1  memory write strobe, held until mem_ready
- mem_addr  out  ADDR_W  memory line address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion, one cycle

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - A requester is pending if its read|write is asserted.
  - None pending: stay in IDLE.
  - One pending: grant it.
  - Both pending: grant the side NOT recorded in last_grant (two-way round robin).
  - On grant: capture op, addr and wdata into mem_* registers, set owner and last_grant, go to BUSY.
- **BUSY**
  - mem_read/mem_write/mem_addr/mem_wdata are held constant from the registers.
  - Requester inputs are ignored.
  - On mem_ready: register mem_rdata into the owner's rdata register, clear mem_read/mem_write, go to DONE.
- **DONE**
  - The owner's ready is 1 for exactly this cycle; the other ready is 0.
  - The next state is always IDLE.
  - This turnaround guarantees the requester has dropped its request before IDLE evaluates again, so a stale request is never re-granted.
- **Read and write asserted together by one requester:** the write is served first. The read stays asserted and is arbitrated anew (the cache drives write-back-then-refill this way).
- mem_ready in IDLE or DONE is ignored.
- x_rdata holds its last captured value between transactions. Writes do not update x_rdata.
- Reset, including mid-transaction:
  - All outputs go to 0 immediately.
  - FSM goes to IDLE and last_grant goes to I, so D wins the first tie.
  - The in-flight transaction is abandoned; the memory model must tolerate a strobe dropping without mem_ready.

## Timing
- Request seen in IDLE at cycle 0 → mem_* asserted in cycle 1.
- mem_ready in cycle k (k≥1, k=1 allowed) → x_ready and x_rdata in cycle k+1 → IDLE in cycle k+2.
- Minimum request-to-ready latency is 2 cycles; the minimum back-to-back grant spacing is k+2.
- All outputs are registered. There is no combinational path from any input to any output.
- A requester blocked by a tie waits at most one full transaction of the other side (no starvation).

## Structure
- Shared package `mem_arb_pkg`:
  - state enum {IDLE, BUSY, DONE}
  - requester ID constants REQ_I=0, REQ_D=1
  - the default ADDR_W/DATA_W values, reused by the cache blocks
- Sub-module `rr_arb2`:
  - inputs: two pending bits and last_grant
  - outputs: grant valid and grant id
  - purely combinational
- last_grant and owner live in the parent.

## Test plan
- **Single I read:** i_read=1, i_addr=0x0000010; memory returns 0x11223344_55667788_99AABBCC_DDEEFF00 with mem_ready in cycle 3 → mem_read=1 with mem_addr=0x0000010 in cycles 1–3; i_ready=1 and i_rdata equal to that value in cycle 4; d_ready stays 0.
- **Simultaneous first requests after reset:** i_read and d_read (d_addr=0x20) asserted in the same cycle → D served first, then I; both requests held throughout; the grant sequence is D, I.
- **Repeated contention:** both sides hold a request across four transactions → grants alternate D, I, D, I; no side is granted twice in a row.
- **D-cache write then read:** d_write=1 and d_read=1 together, d_wdata=0xDEADBEEF…, addr 0x40 → write transaction first, d_ready pulse, then a read transaction to the same address.
- **Back-to-back with zero memory latency:** mem_ready tied 1 → each transaction is BUSY 1 cycle, DONE 1 cycle; ready pulses every 3 cycles; no extra pulses.
- **Reset in BUSY:** rst_n=0 during a write → mem_write, mem_read and both ready outputs drop to 0 asynchronously; after release, the first tie goes to D.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the cache/memory arbiter and the caches above it.
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
   localparam logic REQ_I = 1'b0;
   localparam logic REQ_D = 1'b1;
   localparam int ADDR_W_DEF = 28;
   localparam int DATA_W_DEF = 128;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick; on a tie the side not granted last time wins.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] pend_i,
   input  logic       last_i,
   output logic       gnt_valid_o,
   output logic       gnt_id_o
);
   always_comb begin
      gnt_valid_o = |pend_i;
      gnt_id_o    = &pend_i ? ~last_i : pend_i[REQ_D];
   end
endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one line-granular memory port between the I-cache and D-cache,
// driving it from registered copies of the granted request.
module cache_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_read,
   input  logic              i_write,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ready,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);
   state_e            state_q;
   logic              last_q, owner_q;
   logic              mem_read_q, mem_write_q, i_ready_q, d_ready_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q, i_rdata_q, d_rdata_q;
   logic              gnt_v, gnt_id, sel_wr;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   rr_arb2 u_arb (
      .pend_i      ({d_read | d_write, i_read | i_write}),
      .last_i      (last_q),
      .gnt_valid_o (gnt_v),
      .gnt_id_o    (gnt_id)
   );

   // A write from the winner goes first; its held read is re-arbitrated afterwards.
   always_comb begin
      sel_wr    = gnt_id ? d_write : i_write;
      sel_addr  = gnt_id ? d_addr  : i_addr;
      sel_wdata = gnt_id ? d_wdata : i_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_q      <= REQ_I;
         owner_q     <= REQ_I;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         i_ready_q   <= 1'b0;
         d_ready_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (gnt_v) begin
               owner_q     <= gnt_id;
               last_q      <= gnt_id;
               mem_write_q <= sel_wr;
               mem_read_q  <= ~sel_wr;
               mem_addr_q  <= sel_addr;
               mem_wdata_q <= sel_wdata;
               state_q     <= BUSY;
            end
            BUSY: if (mem_ready) begin
               mem_read_q  <= 1'b0;
               mem_write_q <= 1'b0;
               if (mem_read_q && owner_q == REQ_I) i_rdata_q <= mem_rdata;
               if (mem_read_q && owner_q == REQ_D) d_rdata_q <= mem_rdata;
               i_ready_q   <= owner_q == REQ_I;
               d_ready_q   <= owner_q == REQ_D;
               state_q     <= DONE;
            end
            DONE: begin
               i_ready_q <= 1'b0;
               d_ready_q <= 1'b0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign i_ready   = i_ready_q;
   assign d_ready   = d_ready_q;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed and random transactions checked against a transaction-level
// model (round-robin winner, write-before-read, line memory held in an associative array).
module tb_cache_mem_arbiter;
   localparam int AW = 28;
   localparam int DW = 128;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          i_read = 1'b0, i_write = 1'b0, d_read = 1'b0, d_write = 1'b0;
   logic [AW-1:0] i_addr = '0, d_addr = '0;
   logic [DW-1:0] i_wdata = '0, d_wdata = '0, mem_rdata = '0;
   logic          mem_ready = 1'b0;
   logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
   logic [AW-1:0] mem_addr;
   logic          i_ready, d_ready, mem_read, mem_write;

   int n_cmp = 0, n_bad = 0, cyc = 0, pulses = 0, exp_pulses = 0, last_done = -1;
   logic [DW-1:0] memv [logic [AW-1:0]];
   logic          last_m = 1'b0;
   logic [DW-1:0] exp_ir = '0, exp_dr = '0;

   cache_mem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
      .i_rdata(i_rdata), .i_ready(i_ready),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) pulses += int'(i_ready) + int'(d_ready);

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk1({tag, "_mem_read"}, mem_read, 1'b0);
      chk1({tag, "_mem_write"}, mem_write, 1'b0);
      chk1({tag, "_i_ready"}, i_ready, 1'b0);
      chk1({tag, "_d_ready"}, d_ready, 1'b0);
      chk({tag, "_mem_addr"}, DW'(mem_addr), '0);
      chk({tag, "_mem_wdata"}, mem_wdata, '0);
      chk({tag, "_i_rdata"}, i_rdata, '0);
      chk({tag, "_d_rdata"}, d_rdata, '0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      step();
      chk_all_zero("reset");
      rst_n  = 1'b1;
      last_m = 1'b0;
      exp_ir = '0;
      exp_dr = '0;
   endtask

   // Called at the negedge of an IDLE cycle with at least one request pending;
   // returns at the negedge of the following IDLE cycle.
   task automatic do_txn(input int k, input bit tie);
      logic          pi, pd, win, wr;
      logic [AW-1:0] a;
      logic [DW-1:0] wd, rd;
      pi = i_read | i_write;
      pd = d_read | d_write;
      win = (pi && pd) ? ~last_m : pd;
      last_m = win;
      wr = win ? d_write : i_write;
      a  = win ? d_addr  : i_addr;
      wd = win ? d_wdata : i_wdata;
      if (!memv.exists(a)) memv[a] = rnd128();
      rd = memv[a];
      step();
      for (int t = 1; t <= k; t++) begin
         chk1("mem_read", mem_read, !wr);
         chk1("mem_write", mem_write, wr);
         chk("mem_addr", DW'(mem_addr), DW'(a));
         chk("mem_wdata", mem_wdata, wd);
         chk1("busy_i_ready", i_ready, 1'b0);
         chk1("busy_d_ready", d_ready, 1'b0);
         mem_ready = tie || t == k;
         mem_rdata = (t == k && !wr) ? rd : rnd128();
         step();
      end
      exp_pulses++;
      if (wr) memv[a] = wd;
      else if (win) exp_dr = rd;
      else exp_ir = rd;
      chk1("done_i_ready", i_ready, !win);
      chk1("done_d_ready", d_ready, win);
      chk("i_rdata", i_rdata, exp_ir);
      chk("d_rdata", d_rdata, exp_dr);
      chk1("done_mem_read", mem_read, 1'b0);
      chk1("done_mem_write", mem_write, 1'b0);
      if (tie && last_done >= 0) chk1("pulse_spacing_3", (cyc - last_done) == 3, 1'b1);
      last_done = cyc;
      mem_ready = tie ? 1'b1 : 1'(($urandom % 2));
      mem_rdata = rnd128();
      if (win) begin
         if (wr) d_write = 1'b0; else d_read = 1'b0;
      end else begin
         if (wr) i_write = 1'b0; else i_read = 1'b0;
      end
      step();
      chk1("idle_i_ready", i_ready, 1'b0);
      chk1("idle_d_ready", d_ready, 1'b0);
   endtask

   initial begin
      int op;
      do_reset();

      // single I read, memory answers in cycle 3
      memv[28'h10] = 128'h11223344_55667788_99AABBCC_DDEEFF00;
      i_read = 1'b1;
      i_addr = 28'h10;
      do_txn(3, 1'b0);
      chk("single_i_rdata", i_rdata, 128'h11223344_55667788_99AABBCC_DDEEFF00);

      // first tie after reset goes to D, then strict alternation under contention
      do_reset();
      i_addr = 28'h30;
      d_addr = 28'h20;
      for (int n = 0; n < 4; n++) begin
         i_read = 1'b1;
         d_read = 1'b1;
         do_txn(2, 1'b0);
      end
      i_read = 1'b0;
      d_read = 1'b0;

      // D write-back then refill of the same line
      d_write = 1'b1;
      d_read  = 1'b1;
      d_addr  = 28'h40;
      d_wdata = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
      do_txn(2, 1'b0);
      do_txn(1, 1'b0);
      chk("wr_then_rd", d_rdata, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);

      // memory ready tied high: a pulse every 3 cycles
      mem_ready = 1'b1;
      last_done = -1;
      for (int n = 0; n < 6; n++) begin
         i_read = 1'b1;
         d_read = 1'b1;
         do_txn(1, 1'b1);
      end
      i_read = 1'b0;
      d_read = 1'b0;
      mem_ready = 1'b0;

      // random traffic
      for (int n = 0; n < 40; n++) begin
         if (!(i_read | i_write) && ($urandom % 2) == 1) begin
            op = int'($urandom % 4);
            i_read  = op != 1;
            i_write = op == 1 || op == 2;
            i_addr  = AW'($urandom_range(0, 7));
            i_wdata = rnd128();
         end
         if (!(d_read | d_write) && ($urandom % 2) == 1) begin
            op = int'($urandom % 4);
            d_read  = op != 1;
            d_write = op == 1 || op == 2;
            d_addr  = AW'($urandom_range(0, 7));
            d_wdata = rnd128();
         end
         if (!(i_read | i_write | d_read | d_write)) begin
            i_read = 1'b1;
            i_addr = AW'($urandom_range(0, 7));
         end
         mem_ready = 1'($urandom % 2);
         do_txn(int'($urandom_range(1, 4)), 1'b0);
      end

      // reset while a write is in flight
      i_read = 1'b0; i_write = 1'b0; d_read = 1'b0; d_write = 1'b0;
      mem_ready = 1'b0;
      step();
      d_write = 1'b1;
      d_addr  = 28'h55;
      d_wdata = rnd128();
      step();
      chk1("pre_reset_mem_write", mem_write, 1'b1);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("async_reset");
      d_write = 1'b0;
      i_read = 1'b1; i_addr = 28'h3;
      d_read = 1'b1; d_addr = 28'h4;
      @(negedge clk);
      rst_n  = 1'b1;
      last_m = 1'b0;
      exp_ir = '0;
      exp_dr = '0;
      do_txn(2, 1'b0);
      do_txn(1, 1'b0);

      chk("ready_pulse_count", DW'(pulses), DW'(exp_pulses));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
